mem_access: RTL

- Memory-access stage directly downstream of the execute stage.
- Takes the combinational load/store request the execute stage produces (address, store data, byte strobe, load code) and runs a valid/ready transaction on the 64-bit data-memory port.
- Aligns store data and strobes to the 8-byte bus lane, and extracts plus sign/zero-extends load data.
- Presents one registered writeback result per instruction and stalls upstream while a memory transaction is outstanding.

---
 rtl/mem_access.sv | 159 +++++++++++++++
 1 files changed

// File: rtl/mem_access.sv
// Memory-access stage: turns the execute stage's load/store request into a
// valid/ready transaction on a 64-bit data port, lane-aligns stores, extracts
// and extends loads, and presents one registered writeback result per instruction.
module mem_access #(
    parameter int unsigned ADDR_W = 64
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [2:0]        load_code,
    input  logic              mem_rd_en,
    input  logic [ADDR_W-1:0] addr_mem_rd,
    input  logic              mem_wr_en,
    input  logic [ADDR_W-1:0] addr_mem_wr,
    input  logic [63:0]       data_mem_wr,
    input  logic [7:0]        strb_mem_wr,
    input  logic [63:0]       alu_result,
    input  logic [4:0]        rd_addr,
    output logic              mem_req_valid,
    input  logic              mem_req_ready,
    output logic              mem_req_we,
    output logic [ADDR_W-1:0] mem_req_addr,
    output logic [63:0]       mem_req_wdata,
    output logic [7:0]        mem_req_strb,
    input  logic              mem_resp_valid,
    input  logic [63:0]       mem_resp_rdata,
    output logic              wb_valid,
    input  logic              wb_ready,
    output logic [63:0]       wb_data,
    output logic [4:0]        wb_rd,
    output logic              misalign_err
);

    localparam int unsigned DATA_W = 64;

    typedef enum logic [1:0] {
        StIdle,
        StReq,
        StWait
    } state_e;

    state_e            state;
    logic [2:0]        offset;
    logic [2:0]        code;
    logic              is_store;
    logic [4:0]        rd_hold;

    logic              acc_mem;
    logic [ADDR_W-1:0] acc_addr;
    logic [1:0]        acc_size;
    logic              acc_misaligned;
    logic [DATA_W-1:0] load_raw;
    logic [DATA_W-1:0] load_ext;

    assign in_ready = (state == StIdle) && (!wb_valid || wb_ready);

    // Decode the incoming request: a store wins over a load when both are set.
    always_comb begin
        acc_mem  = mem_wr_en || mem_rd_en;
        acc_addr = mem_wr_en ? addr_mem_wr : addr_mem_rd;
        acc_size = 2'd0;
        if (mem_wr_en) begin
            // Access size of a store is implied by its right-justified strobe.
            if (strb_mem_wr[7])      acc_size = 2'd3;
            else if (strb_mem_wr[3]) acc_size = 2'd2;
            else if (strb_mem_wr[1]) acc_size = 2'd1;
            else                     acc_size = 2'd0;
        end else begin
            acc_size = load_code[1:0];
        end
        case (acc_size)
            2'd1:    acc_misaligned = acc_addr[0];
            2'd2:    acc_misaligned = |acc_addr[1:0];
            2'd3:    acc_misaligned = |acc_addr[2:0];
            default: acc_misaligned = 1'b0;
        endcase
    end

    // Extract the addressed bytes from the returned beat and extend them.
    always_comb begin
        load_raw = mem_resp_rdata >> {offset, 3'b000};
        case (code)
            3'b000:  load_ext = {{56{load_raw[7]}}, load_raw[7:0]};
            3'b001:  load_ext = {{48{load_raw[15]}}, load_raw[15:0]};
            3'b010:  load_ext = {{32{load_raw[31]}}, load_raw[31:0]};
            3'b100:  load_ext = {56'd0, load_raw[7:0]};
            3'b101:  load_ext = {48'd0, load_raw[15:0]};
            3'b110:  load_ext = {32'd0, load_raw[31:0]};
            default: load_ext = load_raw;
        endcase
    end

    // Stage FSM with registered request, writeback and error outputs.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state         <= StIdle;
            offset        <= 3'd0;
            code          <= 3'd0;
            is_store      <= 1'b0;
            rd_hold       <= 5'd0;
            mem_req_valid <= 1'b0;
            mem_req_we    <= 1'b0;
            mem_req_addr  <= '0;
            mem_req_wdata <= '0;
            mem_req_strb  <= 8'd0;
            wb_valid      <= 1'b0;
            wb_data       <= '0;
            wb_rd         <= 5'd0;
            misalign_err  <= 1'b0;
        end else begin
            misalign_err <= 1'b0;
            // Consumer took the result; a new result below may reload it.
            if (wb_valid && wb_ready) begin
                wb_valid <= 1'b0;
            end
            case (state)
                StIdle: begin
                    if (in_valid && in_ready) begin
                        if (!acc_mem) begin
                            wb_valid <= 1'b1;
                            wb_data  <= alu_result;
                            wb_rd    <= rd_addr;
                        end else if (acc_misaligned) begin
                            misalign_err <= 1'b1;
                        end else begin
                            offset        <= acc_addr[2:0];
                            code          <= load_code;
                            is_store      <= mem_wr_en;
                            rd_hold       <= rd_addr;
                            mem_req_valid <= 1'b1;
                            mem_req_we    <= mem_wr_en;
                            mem_req_addr  <= {acc_addr[ADDR_W-1:3], 3'b000};
                            mem_req_wdata <= data_mem_wr << {acc_addr[2:0], 3'b000};
                            mem_req_strb  <= strb_mem_wr << acc_addr[2:0];
                            state         <= StReq;
                        end
                    end
                end
                StReq: begin
                    if (mem_req_ready) begin
                        mem_req_valid <= 1'b0;
                        state         <= StWait;
                    end
                end
                StWait: begin
                    if (mem_resp_valid) begin
                        wb_valid <= 1'b1;
                        wb_data  <= is_store ? '0 : load_ext;
                        wb_rd    <= is_store ? 5'd0 : rd_hold;
                        state    <= StIdle;
                    end
                end
                default: state <= StIdle;
            endcase
        end
    end

endmodule
